pdua_control_unit: RTL

- Hardwired fetch/decode/execute controller for the PDUA datapath.
- Consumes the IR opcode (out_IR) and the registered ALU flags (C, N, P, Z).
- Drives every datapath control line: register bank, MAR/MDR/IR enables, ALU op/shift, memory direction.
- Sits directly above PDUA; together they form the complete processor.

---
 rtl/pdua_cu_pkg.sv | 88 ++++++++
 rtl/pdua_cu_decode.sv | 43 ++++
 rtl/pdua_control_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/pdua_cu_pkg.sv
// Shared types and constants for the PDUA control unit: state encoding, opcodes,
// ALU select codes, register-bank addresses and the packed control-word layout.
package pdua_cu_pkg;

    localparam int unsigned CU_MAX_WIDTH  = 8;
    localparam int unsigned CU_ADDR_WIDTH = 3;
    localparam int unsigned CU_OP_WIDTH   = 5;

    typedef enum logic [4:0] {
        S_INIT,
        S_FETCH0,
        S_FETCH1,
        S_FETCH2,
        S_DECODE,
        S_MOV_ACC_A,
        S_MOV_A_ACC,
        S_CTE_MAR,
        S_CTE_MDR,
        S_CTE_ACC,
        S_CTE_INC,
        S_LD_MAR,
        S_LD_MDR,
        S_LD_ACC,
        S_ST_MAR,
        S_ST_MDR,
        S_MOV_DPTR,
        S_NOT,
        S_AND,
        S_ADD,
        S_SHL,
        S_SHR,
        S_JMP_MAR,
        S_JMP_MDR,
        S_JMP_PC,
        S_JSKIP,
        S_HALT
    } state_t;

    localparam logic [CU_OP_WIDTH-1:0] OP_NOP         = 5'b00000;
    localparam logic [CU_OP_WIDTH-1:0] OP_MOV_ACC_A   = 5'b00001;
    localparam logic [CU_OP_WIDTH-1:0] OP_MOV_A_ACC   = 5'b00010;
    localparam logic [CU_OP_WIDTH-1:0] OP_MOV_ACC_CTE = 5'b00011;
    localparam logic [CU_OP_WIDTH-1:0] OP_MOV_ACC_IND = 5'b00100;
    localparam logic [CU_OP_WIDTH-1:0] OP_MOV_IND_ACC = 5'b00101;
    localparam logic [CU_OP_WIDTH-1:0] OP_MOV_DPTR    = 5'b00110;
    localparam logic [CU_OP_WIDTH-1:0] OP_NOT         = 5'b00111;
    localparam logic [CU_OP_WIDTH-1:0] OP_AND         = 5'b01000;
    localparam logic [CU_OP_WIDTH-1:0] OP_ADD         = 5'b01001;
    localparam logic [CU_OP_WIDTH-1:0] OP_SHL         = 5'b01010;
    localparam logic [CU_OP_WIDTH-1:0] OP_SHR         = 5'b01011;
    localparam logic [CU_OP_WIDTH-1:0] OP_JMP         = 5'b01100;
    localparam logic [CU_OP_WIDTH-1:0] OP_JZ          = 5'b01101;
    localparam logic [CU_OP_WIDTH-1:0] OP_JN          = 5'b01110;
    localparam logic [CU_OP_WIDTH-1:0] OP_JC          = 5'b01111;
    localparam logic [CU_OP_WIDTH-1:0] OP_HALT        = 5'b11111;

    localparam logic [2:0] SEL_PASSB = 3'b000;
    localparam logic [2:0] SEL_AND   = 3'b001;
    localparam logic [2:0] SEL_ADD   = 3'b010;
    localparam logic [2:0] SEL_NOT   = 3'b011;
    localparam logic [2:0] SEL_INC   = 3'b100;
    localparam logic [2:0] SEL_SHL   = 3'b101;
    localparam logic [2:0] SEL_SHR   = 3'b110;

    localparam logic [CU_ADDR_WIDTH-1:0] REG_PC   = 3'd0;
    localparam logic [CU_ADDR_WIDTH-1:0] REG_DPTR = 3'd2;
    localparam logic [CU_ADDR_WIDTH-1:0] REG_A    = 3'd3;
    localparam logic [CU_ADDR_WIDTH-1:0] REG_ACC  = 3'd7;

    typedef struct packed {
        logic                     sclr;
        logic                     ir_en;
        logic                     mar_en;
        logic                     mdr_en;
        logic                     mdr_alu_n;
        logic                     wr_rdn;
        logic                     enaf;
        logic [2:0]               selop;
        logic [1:0]               shamt;
        logic                     bank_wr_en;
        logic [CU_ADDR_WIDTH-1:0] busb;
        logic [CU_ADDR_WIDTH-1:0] busc;
        logic                     halted;
        logic                     illegal_op;
        logic                     instr_start;
    } ctrl_t;

endpackage

// File: rtl/pdua_cu_decode.sv
// Combinational opcode decoder: picks the first execute state for the opcode in IR
// (conditional jumps resolved here from the flags) and flags undefined opcodes.
module pdua_cu_decode
    import pdua_cu_pkg::*;
(
    input  logic [CU_OP_WIDTH-1:0] opcode,
    input  logic                   flag_c,
    input  logic                   flag_n,
    input  logic                   flag_z,
    output state_t                 first_state,
    output logic                   illegal
);

    always_comb begin
        first_state = S_FETCH0;
        illegal     = 1'b0;
        case (opcode)
            OP_NOP:         first_state = S_FETCH0;
            OP_MOV_ACC_A:   first_state = S_MOV_ACC_A;
            OP_MOV_A_ACC:   first_state = S_MOV_A_ACC;
            OP_MOV_ACC_CTE: first_state = S_CTE_MAR;
            OP_MOV_ACC_IND: first_state = S_LD_MAR;
            OP_MOV_IND_ACC: first_state = S_ST_MAR;
            OP_MOV_DPTR:    first_state = S_MOV_DPTR;
            OP_NOT:         first_state = S_NOT;
            OP_AND:         first_state = S_AND;
            OP_ADD:         first_state = S_ADD;
            OP_SHL:         first_state = S_SHL;
            OP_SHR:         first_state = S_SHR;
            OP_JMP:         first_state = S_JMP_MAR;
            // A not-taken branch still has to step PC past its operand byte
            OP_JZ:          first_state = flag_z ? S_JMP_MAR : S_JSKIP;
            OP_JN:          first_state = flag_n ? S_JMP_MAR : S_JSKIP;
            OP_JC:          first_state = flag_c ? S_JMP_MAR : S_JSKIP;
            OP_HALT:        first_state = S_HALT;
            default: begin
                first_state = S_FETCH0;
                illegal     = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/pdua_control_unit.sv
// Hardwired fetch/decode/execute controller for the PDUA datapath.
// Optional memory wait states via `define PDUA_CU_MEM_WAIT_EN (adds mem_ready).
module pdua_control_unit
    import pdua_cu_pkg::*;
#(
    parameter int unsigned MAX_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned OP_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [OP_WIDTH-1:0]   out_IR,
    input  logic                  C,
    input  logic                  N,
    input  logic                  P,
    input  logic                  Z,
`ifdef PDUA_CU_MEM_WAIT_EN
    input  logic                  mem_ready,
`endif
    output logic                  sclr,
    output logic                  ir_en,
    output logic                  mar_en,
    output logic                  mdr_en,
    output logic                  mdr_alu_n,
    output logic                  wr_rdn,
    output logic                  enaf,
    output logic [2:0]            selop,
    output logic [1:0]            shamt,
    output logic                  bank_wr_en,
    output logic [ADDR_WIDTH-1:0] BusB_addr,
    output logic [ADDR_WIDTH-1:0] BusC_addr,
    output logic                  halted,
    output logic                  illegal_op,
    output logic                  instr_start
);

    if (MAX_WIDTH != CU_MAX_WIDTH || OP_WIDTH != CU_OP_WIDTH ||
        ADDR_WIDTH < CU_ADDR_WIDTH) begin : g_bad_cfg
        $error("pdua_control_unit: parameters disagree with pdua_cu_pkg constants");
    end

    state_t state;
    state_t state_nxt;
    state_t dec_state;
    logic   dec_illegal;
    logic   mem_go;
    ctrl_t  ctrl;
    ctrl_t  ctrl_q;
    logic   flag_p_unused;

    assign flag_p_unused = P;

`ifdef PDUA_CU_MEM_WAIT_EN
    assign mem_go = mem_ready;
`else
    assign mem_go = 1'b1;
`endif

    pdua_cu_decode u_decode (
        .opcode      (out_IR),
        .flag_c      (C),
        .flag_n      (N),
        .flag_z      (Z),
        .first_state (dec_state),
        .illegal     (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        ctrl      = '0;
        state_nxt = state;
        case (state)
            S_INIT: begin
                ctrl.sclr = 1'b1;
                state_nxt = S_FETCH0;
            end
            S_FETCH0: begin
                ctrl.busb        = REG_PC;
                ctrl.selop       = SEL_PASSB;
                ctrl.mar_en      = 1'b1;
                ctrl.instr_start = 1'b1;
                state_nxt        = S_FETCH1;
            end
            S_FETCH1: begin
                ctrl.mdr_en = mem_go;
                if (mem_go) state_nxt = S_FETCH2;
            end
            S_FETCH2: begin
                ctrl.ir_en      = 1'b1;
                ctrl.busb       = REG_PC;
                ctrl.selop      = SEL_INC;
                ctrl.bank_wr_en = 1'b1;
                ctrl.busc       = REG_PC;
                state_nxt       = S_DECODE;
            end
            S_DECODE: begin
                ctrl.illegal_op = dec_illegal;
                state_nxt       = dec_state;
            end
            S_MOV_ACC_A: begin
                ctrl.busb       = REG_A;
                ctrl.selop      = SEL_PASSB;
                ctrl.busc       = REG_ACC;
                ctrl.bank_wr_en = 1'b1;
                ctrl.enaf       = 1'b1;
                state_nxt       = S_FETCH0;
            end
            S_MOV_A_ACC: begin
                ctrl.busb       = REG_ACC;
                ctrl.selop      = SEL_PASSB;
                ctrl.busc       = REG_A;
                ctrl.bank_wr_en = 1'b1;
                state_nxt       = S_FETCH0;
            end
            S_CTE_MAR, S_JMP_MAR: begin
                ctrl.busb   = REG_PC;
                ctrl.selop  = SEL_PASSB;
                ctrl.mar_en = 1'b1;
                state_nxt   = (state == S_CTE_MAR) ? S_CTE_MDR : S_JMP_MDR;
            end
            S_LD_MAR, S_ST_MAR: begin
                ctrl.busb   = REG_DPTR;
                ctrl.selop  = SEL_PASSB;
                ctrl.mar_en = 1'b1;
                state_nxt   = (state == S_LD_MAR) ? S_LD_MDR : S_ST_MDR;
            end
            // Operand reads share one body; only the follow-on state differs
            S_CTE_MDR, S_LD_MDR, S_JMP_MDR: begin
                ctrl.mdr_en = mem_go;
                if (mem_go) begin
                    case (state)
                        S_CTE_MDR: state_nxt = S_CTE_ACC;
                        S_LD_MDR:  state_nxt = S_LD_ACC;
                        default:   state_nxt = S_JMP_PC;
                    endcase
                end
            end
            S_CTE_ACC, S_LD_ACC: begin
                ctrl.mdr_alu_n  = 1'b1;
                ctrl.busc       = REG_ACC;
                ctrl.bank_wr_en = 1'b1;
                state_nxt       = (state == S_CTE_ACC) ? S_CTE_INC : S_FETCH0;
            end
            S_CTE_INC, S_JSKIP: begin
                ctrl.busb       = REG_PC;
                ctrl.selop      = SEL_INC;
                ctrl.busc       = REG_PC;
                ctrl.bank_wr_en = 1'b1;
                state_nxt       = S_FETCH0;
            end
            S_JMP_PC: begin
                ctrl.mdr_alu_n  = 1'b1;
                ctrl.busc       = REG_PC;
                ctrl.bank_wr_en = 1'b1;
                state_nxt       = S_FETCH0;
            end
            S_ST_MDR: begin
                ctrl.busb   = REG_ACC;
                ctrl.selop  = SEL_PASSB;
                ctrl.wr_rdn = 1'b1;
                ctrl.mdr_en = mem_go;
                if (mem_go) state_nxt = S_FETCH0;
            end
            S_MOV_DPTR: begin
                ctrl.busb       = REG_ACC;
                ctrl.selop      = SEL_PASSB;
                ctrl.busc       = REG_DPTR;
                ctrl.bank_wr_en = 1'b1;
                state_nxt       = S_FETCH0;
            end
            S_NOT, S_AND, S_ADD, S_SHL, S_SHR: begin
                ctrl.busc       = REG_ACC;
                ctrl.bank_wr_en = 1'b1;
                ctrl.enaf       = 1'b1;
                state_nxt       = S_FETCH0;
                case (state)
                    S_NOT: ctrl.selop = SEL_NOT;
                    S_AND: begin ctrl.selop = SEL_AND; ctrl.busb = REG_A; end
                    S_ADD: begin ctrl.selop = SEL_ADD; ctrl.busb = REG_A; end
                    S_SHL: begin ctrl.selop = SEL_SHL; ctrl.shamt = 2'b01; end
                    default: begin ctrl.selop = SEL_SHR; ctrl.shamt = 2'b01; end
                endcase
            end
            S_HALT: begin
                ctrl.halted = 1'b1;
            end
            default: begin
                state_nxt = S_INIT;
            end
        endcase
    end

    // Gating with rst keeps the reset cycle free of strobes even mid-instruction
    assign ctrl_q = rst ? ctrl : '0;

    assign sclr        = ctrl_q.sclr;
    assign ir_en       = ctrl_q.ir_en;
    assign mar_en      = ctrl_q.mar_en;
    assign mdr_en      = ctrl_q.mdr_en;
    assign mdr_alu_n   = ctrl_q.mdr_alu_n;
    assign wr_rdn      = ctrl_q.wr_rdn;
    assign enaf        = ctrl_q.enaf;
    assign selop       = ctrl_q.selop;
    assign shamt       = ctrl_q.shamt;
    assign bank_wr_en  = ctrl_q.bank_wr_en;
    assign BusB_addr   = ADDR_WIDTH'(ctrl_q.busb);
    assign BusC_addr   = ADDR_WIDTH'(ctrl_q.busc);
    assign halted      = ctrl_q.halted;
    assign illegal_op  = ctrl_q.illegal_op;
    assign instr_start = ctrl_q.instr_start;

endmodule
